fu_complete_arbiter: RTL and testbench

Complete-stage arbiter between the functional units (ALU, multiplier, load, branch) and the complete/CDB ports. Each cycle it grants up to COMPLETE_WIDTH of the FUs asserting want_to_complete, in round-robin order. It registers the granted FU_COMPLETE_PACKETs onto the CDB and drives a per-FU complete_stall so that losing FUs hold their output register.

---
 rtl/sys_defs.sv | 23 ++
 rtl/fu_complete_arbiter_rr_select.sv | 43 ++++
 rtl/fu_complete_arbiter.sv | 136 +++++++++++++
 tb/tb_fu_complete_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the complete stage: functional-unit result packet,
// default arbiter sizing and functional-unit index constants.
package sys_defs;

  localparam int NUM_FU         = 4;
  localparam int COMPLETE_WIDTH = 2;

  localparam int FU_BRANCH = 0;
  localparam int FU_ALU    = 1;
  localparam int FU_MULT   = 2;
  localparam int FU_LOAD   = 3;

  typedef struct packed {
    logic        valid;
    logic        if_take_branch;
    logic [31:0] target_pc;
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
    logic [4:0]  rob_entry;
    logic        halt;
  } FU_COMPLETE_PACKET;

endpackage

// File: rtl/fu_complete_arbiter_rr_select.sv
// rr_select: find-first-N-from-pointer selector. Scans i_req ascending
// (modulo N) starting at i_ptr and grants the first i_limit requesters.
// Slot k reports the k-th grant in scan order; o_last_idx is the final grant.
module rr_select #(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int PW = 2,
  parameter int LW = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [PW-1:0]        i_ptr,
  input  logic [LW-1:0]        i_limit,
  output logic [N-1:0]         o_grant,
  output logic [W-1:0]         o_slot_valid,
  output logic [W-1:0][PW-1:0] o_slot_idx,
  output logic [PW-1:0]        o_last_idx,
  output logic                 o_any
);

  // Walk every position once from the pointer, filling slots in scan order.
  always_comb begin
    int w_cnt;
    int w_idx;
    o_grant      = '0;
    o_slot_valid = '0;
    o_slot_idx   = '0;
    o_last_idx   = '0;
    w_cnt        = 0;
    w_idx        = 0;
    for (int off = 0; off < N; off++) begin
      w_idx = (int'(i_ptr) + off) % N;
      if (i_req[w_idx] && (w_cnt < int'(i_limit))) begin
        o_grant[w_idx]      = 1'b1;
        o_slot_valid[w_cnt] = 1'b1;
        o_slot_idx[w_cnt]   = PW'(w_idx);
        o_last_idx          = PW'(w_idx);
        w_cnt               = w_cnt + 1;
      end
    end
    o_any = |o_grant;
  end

endmodule

// File: rtl/fu_complete_arbiter.sv
// fu_complete_arbiter: grants up to COMPLETE_WIDTH functional units per cycle
// onto the CDB in round-robin order, registers the granted packets and
// stalls the losers combinationally.
// Optional feature macro: BRANCH_PRIORITY_EN -- FU 0 (branch) always takes
// slot 0 when it requests; the round-robin covers FUs 1..NUM_FU-1 only.
module fu_complete_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU         = sys_defs::NUM_FU,
  parameter int COMPLETE_WIDTH = sys_defs::COMPLETE_WIDTH,
  parameter int PTR_W          = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic              [NUM_FU-1:0]         want_to_complete,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0]         fu_packet_in,
  input  logic                                   squash,
  output logic              [NUM_FU-1:0]         complete_stall,
  output FU_COMPLETE_PACKET [COMPLETE_WIDTH-1:0] cdb_packet,
  output logic              [PTR_W-1:0]          rr_ptr_dbg
);

  localparam int LIM_W = $clog2(COMPLETE_WIDTH + 1);

  logic              [PTR_W-1:0]                    r_rr_ptr;
  FU_COMPLETE_PACKET [COMPLETE_WIDTH-1:0]           r_cdb;

  logic              [NUM_FU-1:0]                   w_rr_req;
  logic              [LIM_W-1:0]                    w_limit;
  logic                                             w_branch;
  logic              [NUM_FU-1:0]                   w_rr_grant;
  logic              [COMPLETE_WIDTH-1:0]           w_rr_valid;
  logic              [COMPLETE_WIDTH-1:0][PTR_W-1:0] w_rr_idx;
  logic              [PTR_W-1:0]                    w_rr_last;
  logic                                             w_rr_any;
  logic              [NUM_FU-1:0]                   w_grant;
  logic              [COMPLETE_WIDTH-1:0]           w_slot_valid;
  logic              [COMPLETE_WIDTH-1:0][PTR_W-1:0] w_slot_idx;
  logic              [PTR_W-1:0]                    w_ptr_nxt;
  FU_COMPLETE_PACKET [COMPLETE_WIDTH-1:0]           w_cdb_nxt;

  // Squash removes every request before arbitration; branch may bypass the scan.
  always_comb begin
`ifdef BRANCH_PRIORITY_EN
    w_branch = want_to_complete[0] & ~squash;
    w_rr_req = squash ? '0 : (want_to_complete & ~NUM_FU'(1));
    w_limit  = w_branch ? LIM_W'(COMPLETE_WIDTH - 1) : LIM_W'(COMPLETE_WIDTH);
`else
    w_branch = 1'b0;
    w_rr_req = squash ? '0 : want_to_complete;
    w_limit  = LIM_W'(COMPLETE_WIDTH);
`endif
  end

  rr_select #(
    .N  (NUM_FU),
    .W  (COMPLETE_WIDTH),
    .PW (PTR_W),
    .LW (LIM_W)
  ) u_rr_select (
    .i_req        (w_rr_req),
    .i_ptr        (r_rr_ptr),
    .i_limit      (w_limit),
    .o_grant      (w_rr_grant),
    .o_slot_valid (w_rr_valid),
    .o_slot_idx   (w_rr_idx),
    .o_last_idx   (w_rr_last),
    .o_any        (w_rr_any)
  );

  // Merge an optional branch grant in front of the round-robin slots.
  always_comb begin
    w_grant      = w_rr_grant;
    w_slot_valid = w_rr_valid;
    w_slot_idx   = w_rr_idx;
    if (w_branch) begin
      w_grant[0]      = 1'b1;
      w_slot_valid[0] = 1'b1;
      w_slot_idx[0]   = '0;
      for (int k = 1; k < COMPLETE_WIDTH; k++) begin
        w_slot_valid[k] = w_rr_valid[k-1];
        w_slot_idx[k]   = w_rr_idx[k-1];
      end
    end
  end

  // Losers hold; nothing stalls during squash or while reset is asserted.
  always_comb begin
    complete_stall = '0;
    if (reset && !squash) begin
      complete_stall = want_to_complete & ~w_grant;
    end
  end

  // Pointer moves past the last round-robin grant; a branch-only grant leaves it.
  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    if (w_rr_any) begin
      if (w_rr_last == PTR_W'(NUM_FU - 1)) begin
`ifdef BRANCH_PRIORITY_EN
        w_ptr_nxt = PTR_W'(1);
`else
        w_ptr_nxt = '0;
`endif
      end else begin
        w_ptr_nxt = w_rr_last + PTR_W'(1);
      end
    end
  end

  // Granted slots carry the FU packet with valid forced high; empty slots are zero.
  always_comb begin
    w_cdb_nxt = '0;
    for (int k = 0; k < COMPLETE_WIDTH; k++) begin
      if (w_slot_valid[k]) begin
        w_cdb_nxt[k]       = fu_packet_in[w_slot_idx[k]];
        w_cdb_nxt[k].valid = 1'b1;
      end
    end
  end

  // Pointer and CDB registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_cdb    <= '0;
    end else begin
      r_rr_ptr <= w_ptr_nxt;
      r_cdb    <= w_cdb_nxt;
    end
  end

  assign cdb_packet = r_cdb;
  assign rr_ptr_dbg = r_rr_ptr;

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed bench for fu_complete_arbiter with NUM_FU=4, COMPLETE_WIDTH=2.
// Build with BRANCH_PRIORITY_EN defined to exercise the branch-priority path.
module tb_fu_complete_arbiter;
  import sys_defs::*;

  logic                                   clock;
  logic                                   reset;
  logic              [3:0]                want_to_complete;
  FU_COMPLETE_PACKET [3:0]                fu_packet_in;
  logic                                   squash;
  logic              [3:0]                complete_stall;
  FU_COMPLETE_PACKET [1:0]                cdb_packet;
  logic              [1:0]                rr_ptr_dbg;

  int n_chk;
  int n_pass;

  fu_complete_arbiter #(
    .NUM_FU         (4),
    .COMPLETE_WIDTH (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .want_to_complete (want_to_complete),
    .fu_packet_in     (fu_packet_in),
    .squash           (squash),
    .complete_stall   (complete_stall),
    .cdb_packet       (cdb_packet),
    .rr_ptr_dbg       (rr_ptr_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // dest_pr per FU: branch=2, ALU=5, MULT=9, LOAD=12
  function automatic logic [5:0] fu_dp(input int i);
    case (i)
      0: return 6'd2;
      1: return 6'd5;
      2: return 6'd9;
      default: return 6'd12;
    endcase
  endfunction

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    squash = 1'b0;
    want_to_complete = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fu_packet_in[i]            = '0;
      fu_packet_in[i].dest_pr    = fu_dp(i);
      fu_packet_in[i].dest_value = 32'(100 + i);
      fu_packet_in[i].rob_entry  = 5'(i + 1);
    end
    #3;
    chk("rst_v0", 64'(cdb_packet[0].valid), 64'd0);
    chk("rst_v1", 64'(cdb_packet[1].valid), 64'd0);
    chk("rst_ptr", 64'(rr_ptr_dbg), 64'd0);
    chk("rst_stall", 64'(complete_stall), 64'd0);
    want_to_complete = 4'b0000;
    #4 reset = 1'b1;
    tick();

`ifdef BRANCH_PRIORITY_EN
    // Move pointer to 2 by granting ALU alone.
    want_to_complete = 4'b0010;
    tick();
    chk("bp_setup_ptr", 64'(rr_ptr_dbg), 64'd2);
    chk("bp_setup_dp", 64'(cdb_packet[0].dest_pr), 64'd5);
    want_to_complete = 4'b1111;
    #1 chk("bp_stall", 64'(complete_stall), 64'b1010);
    tick();
    chk("bp_s0_dp", 64'(cdb_packet[0].dest_pr), 64'd2);
    chk("bp_s1_dp", 64'(cdb_packet[1].dest_pr), 64'd9);
    chk("bp_v", 64'({cdb_packet[1].valid, cdb_packet[0].valid}), 64'b11);
    chk("bp_ptr", 64'(rr_ptr_dbg), 64'd3);
    want_to_complete = 4'b0000;
`else
    // ALU + MULT from pointer 0.
    want_to_complete = 4'b0110;
    #1 chk("a_stall", 64'(complete_stall), 64'b0000);
    tick();
    chk("a_v", 64'({cdb_packet[1].valid, cdb_packet[0].valid}), 64'b11);
    chk("a_s0_dp", 64'(cdb_packet[0].dest_pr), 64'd5);
    chk("a_s1_dp", 64'(cdb_packet[1].dest_pr), 64'd9);
    chk("a_ptr", 64'(rr_ptr_dbg), 64'd3);

    // Pointer 3, LOAD then branch, pointer wraps to 1.
    want_to_complete = 4'b1001;
    #1 chk("b_stall", 64'(complete_stall), 64'b0000);
    tick();
    chk("b_s0_dp", 64'(cdb_packet[0].dest_pr), 64'd12);
    chk("b_s1_dp", 64'(cdb_packet[1].dest_pr), 64'd2);
    chk("b_ptr", 64'(rr_ptr_dbg), 64'd1);
    want_to_complete = 4'b0000;

    // Asynchronous reset with valid packets registered.
    #2 reset = 1'b0;
    #1;
    chk("mr_v0", 64'(cdb_packet[0].valid), 64'd0);
    chk("mr_v1", 64'(cdb_packet[1].valid), 64'd0);
    chk("mr_ptr", 64'(rr_ptr_dbg), 64'd0);
    want_to_complete = 4'b1111;
    #1 chk("mr_stall", 64'(complete_stall), 64'd0);
    want_to_complete = 4'b0000;
    reset = 1'b1;
    tick();
    chk("mr_idle_v", 64'({cdb_packet[1].valid, cdb_packet[0].valid}), 64'b00);
    chk("mr_idle_ptr", 64'(rr_ptr_dbg), 64'd0);

    // All four request; FUs 0/1 win, then drop their requests once granted.
    want_to_complete = 4'b1111;
    #1 chk("c1_stall", 64'(complete_stall), 64'b1100);
    tick();
    chk("c1_s0_dp", 64'(cdb_packet[0].dest_pr), 64'd2);
    chk("c1_s1_dp", 64'(cdb_packet[1].dest_pr), 64'd5);
    chk("c1_ptr", 64'(rr_ptr_dbg), 64'd2);
    want_to_complete = 4'b1100;
    #1 chk("c2_stall", 64'(complete_stall), 64'b0000);
    tick();
    chk("c2_s0_dp", 64'(cdb_packet[0].dest_pr), 64'd9);
    chk("c2_s1_dp", 64'(cdb_packet[1].dest_pr), 64'd12);
    chk("c2_ptr", 64'(rr_ptr_dbg), 64'd0);

    // No requesters.
    want_to_complete = 4'b0000;
    tick();
    chk("idle_v", 64'({cdb_packet[1].valid, cdb_packet[0].valid}), 64'b00);
    chk("idle_ptr", 64'(rr_ptr_dbg), 64'd0);

    // Squash in the same cycle as a taken-branch request.
    fu_packet_in[0].if_take_branch = 1'b1;
    fu_packet_in[0].target_pc      = 32'd8;
    fu_packet_in[0].rob_entry      = 5'd0;
    want_to_complete = 4'b1011;
    squash = 1'b1;
    #1 chk("sq_stall", 64'(complete_stall), 64'b0000);
    tick();
    chk("sq_v", 64'({cdb_packet[1].valid, cdb_packet[0].valid}), 64'b00);
    chk("sq_ptr", 64'(rr_ptr_dbg), 64'd0);

    // Same requests without squash; packet valid forced although input valid=0.
    squash = 1'b0;
    #1 chk("d_stall", 64'(complete_stall), 64'b1000);
    tick();
    chk("d_s0_v", 64'(cdb_packet[0].valid), 64'd1);
    chk("d_s0_tk", 64'(cdb_packet[0].if_take_branch), 64'd1);
    chk("d_s0_pc", 64'(cdb_packet[0].target_pc), 64'd8);
    chk("d_s1_dp", 64'(cdb_packet[1].dest_pr), 64'd5);
    chk("d_ptr", 64'(rr_ptr_dbg), 64'd2);

    // Single requester at the top index: one slot, pointer wraps to 0.
    want_to_complete = 4'b1000;
    #1 chk("e_stall", 64'(complete_stall), 64'b0000);
    tick();
    chk("e_s0_dp", 64'(cdb_packet[0].dest_pr), 64'd12);
    chk("e_s1_v", 64'(cdb_packet[1].valid), 64'd0);
    chk("e_ptr", 64'(rr_ptr_dbg), 64'd0);
    want_to_complete = 4'b0000;
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
